// File: rtl/arithmetic_serial.sv
// Digit-serial ADD/SUB unit: processes DIGIT bits per clock, LSB digit first, and
// presents a registered result with zero/carry/overflow/negative flags on completion.
module arithmetic_serial #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ALUop,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             negative
);

  localparam int unsigned N    = WIDTH / DIGIT;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             cy_q, cy_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             neg_q, neg_d;

  logic             accept;
  logic             last;
  logic             is_sub;
  logic [WIDTH-1:0] b_in;
  logic [DIGIT:0]   digit_sum;
  logic [WIDTH-1:0] acc_shift;
  logic [WIDTH-1:0] a_shift;
  logic [WIDTH-1:0] b_shift;

  // Only ALUop[1] selects the operation.
  logic unused_aluop;
  assign unused_aluop = ^{ALUop[3:2], ALUop[0]};

  assign is_sub = ALUop[1];
  assign b_in   = is_sub ? ~b : b;
  assign accept = start && (state_q != StRun);
  assign last   = (state_q == StRun) && (cnt_q == CntLast);

  assign digit_sum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + (DIGIT + 1)'(cy_q);

  // New sum digit enters at the top of the accumulator; after N shifts it holds the full word.
  if (N == 1) begin : g_single
    assign acc_shift = digit_sum[DIGIT-1:0];
    assign a_shift   = a_q;
    assign b_shift   = b_q;
  end else begin : g_multi
    assign acc_shift = {digit_sum[DIGIT-1:0], acc_q[WIDTH-1:DIGIT]};
    assign a_shift   = {{DIGIT{1'b0}}, a_q[WIDTH-1:DIGIT]};
    assign b_shift   = {{DIGIT{1'b0}}, b_q[WIDTH-1:DIGIT]};
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last) state_d = StDone;
      StDone:  state_d = start ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    busy     = (state_q == StRun);
    done     = (state_q == StDone);
    result   = result_q;
    zero     = zero_q;
    carry    = carry_q;
    overflow = ovf_q;
    negative = neg_q;
  end

  // Datapath next-state
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cy_d     = cy_q;
    cnt_d    = cnt_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    neg_d    = neg_q;
    if (accept) begin
      a_d     = a;
      b_d     = b_in;
      cy_d    = is_sub;
      cnt_d   = '0;
      a_msb_d = a[WIDTH-1];
      b_msb_d = b_in[WIDTH-1];
    end else if (state_q == StRun) begin
      a_d   = a_shift;
      b_d   = b_shift;
      acc_d = acc_shift;
      cy_d  = digit_sum[DIGIT];
      cnt_d = cnt_q + CntW'(1);
      if (last) begin
        result_d = acc_shift;
        zero_d   = (acc_shift == '0);
        carry_d  = digit_sum[DIGIT];
        neg_d    = acc_shift[WIDTH-1];
        ovf_d    = (a_msb_q == b_msb_q) && (acc_shift[WIDTH-1] != a_msb_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cy_q     <= 1'b0;
      cnt_q    <= '0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cy_q     <= cy_d;
      cnt_q    <= cnt_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      neg_q    <= neg_d;
    end
  end

endmodule
